// File: rtl/stage_writeback.sv
// stage_writeback -- final stage of the bfcpu2 datapath.
//
// Commits the modify stage's result: INC/DEC values are written to data
// memory at the data pointer, OUT hands the cell value to the output port
// over a valid/ready handshake, and IN fetches a byte from the input port
// and writes it to data memory. ack is the pipeline-wide stall signal.
//
// Ports:
//   clk, reset          clock; synchronous active-high reset
//   a_in, dp_in         cell value / data pointer from the modify stage
//   operation_in        one-hot opcode (all-zero = bubble)
//   ack                 stage accepts the current operation this cycle
//   mem_we/waddr/wdata  data memory write port (one-cycle strobe)
//   out_valid/out_data/out_ready   output byte handshake
//   in_ready/in_data/in_valid      input byte handshake
//   io_stall_cycles     saturating count of cycles spent waiting on I/O
module stage_writeback #(
   parameter int unsigned D_WIDTH    = 8,
   parameter int unsigned A_WIDTH    = 16,
   parameter int unsigned OPCODE_MSB = 3,
   parameter int unsigned OP_INC     = 0,
   parameter int unsigned OP_DEC     = 1,
   parameter int unsigned OP_IN      = 2,
   parameter int unsigned OP_OUT     = 3
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [D_WIDTH-1:0]  a_in,
   input  logic [A_WIDTH-1:0]  dp_in,
   input  logic [OPCODE_MSB:0] operation_in,
   output logic                ack,
   output logic                mem_we,
   output logic [A_WIDTH-1:0]  mem_waddr,
   output logic [D_WIDTH-1:0]  mem_wdata,
   output logic                out_valid,
   output logic [D_WIDTH-1:0]  out_data,
   input  logic                out_ready,
   output logic                in_ready,
   input  logic [D_WIDTH-1:0]  in_data,
   input  logic                in_valid,
   output logic [15:0]         io_stall_cycles
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WAIT_OUT = 2'd1,
      WAIT_IN  = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic                 mem_we_d;
   logic [A_WIDTH-1:0]   mem_waddr_d;
   logic [D_WIDTH-1:0]   mem_wdata_d;
   logic                 out_valid_d;
   logic [D_WIDTH-1:0]   out_data_d;
   logic                 in_ready_d;
   logic [A_WIDTH-1:0]   in_addr_q, in_addr_d;
   logic [15:0]          stall_d;

   assign ack = (state_q == IDLE);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q         <= IDLE;
         mem_we          <= 1'b0;
         mem_waddr       <= '0;
         mem_wdata       <= '0;
         out_valid       <= 1'b0;
         out_data        <= '0;
         in_ready        <= 1'b0;
         in_addr_q       <= '0;
         io_stall_cycles <= '0;
      end else begin
         state_q         <= state_d;
         mem_we          <= mem_we_d;
         mem_waddr       <= mem_waddr_d;
         mem_wdata       <= mem_wdata_d;
         out_valid       <= out_valid_d;
         out_data        <= out_data_d;
         in_ready        <= in_ready_d;
         in_addr_q       <= in_addr_d;
         io_stall_cycles <= stall_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      mem_we_d    = 1'b0;
      mem_waddr_d = mem_waddr;
      mem_wdata_d = mem_wdata;
      out_valid_d = out_valid;
      out_data_d  = out_data;
      in_ready_d  = in_ready;
      in_addr_d   = in_addr_q;

      unique case (state_q)
         IDLE: begin
            // if/else chain encodes the INC > DEC > IN > OUT priority
            if (operation_in[OP_INC] || operation_in[OP_DEC]) begin
               mem_we_d    = 1'b1;
               mem_waddr_d = dp_in;
               mem_wdata_d = a_in;
            end else if (operation_in[OP_IN]) begin
               in_addr_d  = dp_in;
               in_ready_d = 1'b1;
               state_d    = WAIT_IN;
            end else if (operation_in[OP_OUT]) begin
               out_data_d  = a_in;
               out_valid_d = 1'b1;
               state_d     = WAIT_OUT;
            end
         end
         WAIT_OUT: begin
            if (out_valid && out_ready) begin
               out_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         WAIT_IN: begin
            if (in_valid && in_ready) begin
               mem_we_d    = 1'b1;
               mem_waddr_d = in_addr_q;
               mem_wdata_d = in_data;
               in_ready_d  = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      stall_d = io_stall_cycles;
      if (state_q != IDLE && io_stall_cycles != 16'hFFFF)
         stall_d = io_stall_cycles + 16'd1;
   end

endmodule

// File: tb/tb_stage_writeback.sv
// Directed bench for stage_writeback with a memory-write scoreboard.
module tb_stage_writeback;

   localparam int unsigned D_WIDTH = 8;
   localparam int unsigned A_WIDTH = 16;
   localparam logic [3:0] B_INC = 4'b0001;
   localparam logic [3:0] B_DEC = 4'b0010;
   localparam logic [3:0] B_IN  = 4'b0100;
   localparam logic [3:0] B_OUT = 4'b1000;

   logic               clk = 1'b0;
   logic               reset;
   logic [D_WIDTH-1:0] a_in;
   logic [A_WIDTH-1:0] dp_in;
   logic [3:0]         operation_in;
   logic               ack;
   logic               mem_we;
   logic [A_WIDTH-1:0] mem_waddr;
   logic [D_WIDTH-1:0] mem_wdata;
   logic               out_valid;
   logic [D_WIDTH-1:0] out_data;
   logic               out_ready;
   logic               in_ready;
   logic [D_WIDTH-1:0] in_data;
   logic               in_valid;
   logic [15:0]        io_stall_cycles;

   typedef struct packed {
      logic [A_WIDTH-1:0] addr;
      logic [D_WIDTH-1:0] data;
   } wr_t;

   wr_t exp_q[$];
   int  vectors = 0;
   int  miscompares = 0;
   bit  done = 1'b0;

   stage_writeback #(
      .D_WIDTH(D_WIDTH),
      .A_WIDTH(A_WIDTH),
      .OPCODE_MSB(3),
      .OP_INC(0),
      .OP_DEC(1),
      .OP_IN(2),
      .OP_OUT(3)
   ) dut (
      .clk(clk),
      .reset(reset),
      .a_in(a_in),
      .dp_in(dp_in),
      .operation_in(operation_in),
      .ack(ack),
      .mem_we(mem_we),
      .mem_waddr(mem_waddr),
      .mem_wdata(mem_wdata),
      .out_valid(out_valid),
      .out_data(out_data),
      .out_ready(out_ready),
      .in_ready(in_ready),
      .in_data(in_data),
      .in_valid(in_valid),
      .io_stall_cycles(io_stall_cycles)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [A_WIDTH-1:0] a, input logic [D_WIDTH-1:0] d);
      wr_t w;
      w.addr = a;
      w.data = d;
      exp_q.push_back(w);
   endtask

   // Scoreboard: every memory write must match the oldest expected entry.
   always @(negedge clk) begin
      if (!done && mem_we) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_write", {mem_waddr, mem_wdata}, 32'hFFFF_FFFF);
         end else begin
            wr_t w;
            w = exp_q.pop_front();
            chk("sb_write", {mem_waddr, mem_wdata}, {w.addr, w.data});
         end
      end
   end

   initial begin
      reset = 1'b1; a_in = '0; dp_in = '0; operation_in = '0;
      out_ready = 1'b0; in_data = '0; in_valid = 1'b0;
      @(negedge clk);
      chk("ack_in_reset", ack, 1);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_waddr", mem_waddr, 0);
      chk("rst_wdata", mem_wdata, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_stall", io_stall_cycles, 0);
      chk("rst_ack", ack, 1);

      // INC
      operation_in = B_INC; dp_in = 16'h0005; a_in = 8'h2A;
      chk("inc_ack", ack, 1);
      push(16'h0005, 8'h2A);
      @(negedge clk);
      operation_in = '0;
      chk("inc_we", mem_we, 1);
      chk("inc_waddr", mem_waddr, 32'h0005);
      chk("inc_wdata", mem_wdata, 32'h2A);
      @(negedge clk);
      chk("inc_we_drop", mem_we, 0);

      // Three back-to-back DECs
      for (int i = 1; i <= 3; i++) begin
         operation_in = B_DEC; dp_in = 16'(i); a_in = 8'(8'h0F + i);
         chk("dec_ack", ack, 1);
         push(16'(i), 8'(8'h0F + i));
         @(negedge clk);
         chk("dec_we", mem_we, 1);
         chk("dec_waddr", mem_waddr, 32'(i));
         chk("dec_wdata", mem_wdata, 32'(8'h0F + i));
      end
      operation_in = '0;
      @(negedge clk);
      chk("dec_we_drop", mem_we, 0);

      // OUT with out_ready low for 4 cycles then high
      operation_in = B_OUT; a_in = 8'h41;
      @(negedge clk);
      operation_in = '0; a_in = 8'h00;
      for (int k = 0; k < 5; k++) begin
         chk("out_valid_hold", out_valid, 1);
         chk("out_data_hold", out_data, 32'h41);
         chk("out_ack_low", ack, 0);
         if (k == 4) out_ready = 1'b1;
         @(negedge clk);
      end
      out_ready = 1'b0;
      chk("out_valid_drop", out_valid, 0);
      chk("out_ack_back", ack, 1);
      chk("out_stall", io_stall_cycles, 5);

      // IN with data already valid
      operation_in = B_IN; dp_in = 16'h0100; a_in = 8'h99;
      in_valid = 1'b1; in_data = 8'h7F;
      push(16'h0100, 8'h7F);
      @(negedge clk);
      operation_in = '0;
      chk("in1_ready", in_ready, 1);
      chk("in1_ack_low", ack, 0);
      chk("in1_no_we", mem_we, 0);
      @(negedge clk);
      in_valid = 1'b0;
      chk("in1_we", mem_we, 1);
      chk("in1_waddr", mem_waddr, 32'h0100);
      chk("in1_wdata", mem_wdata, 32'h7F);
      chk("in1_ready_drop", in_ready, 0);
      chk("in1_ack", ack, 1);
      chk("in1_stall", io_stall_cycles, 6);

      // IN with delayed valid; dp_in changes meanwhile
      operation_in = B_IN; dp_in = 16'h0100; in_data = 8'h55;
      push(16'h0100, 8'hC3);
      @(negedge clk);
      operation_in = '0; dp_in = 16'h0200;
      for (int k = 0; k < 3; k++) begin
         chk("in2_ready_wait", in_ready, 1);
         chk("in2_no_we", mem_we, 0);
         in_data = 8'(k);
         @(negedge clk);
      end
      in_data = 8'hC3; in_valid = 1'b1;
      chk("in2_ready", in_ready, 1);
      @(negedge clk);
      in_valid = 1'b0;
      chk("in2_we", mem_we, 1);
      chk("in2_waddr", mem_waddr, 32'h0100);
      chk("in2_wdata", mem_wdata, 32'hC3);
      chk("in2_ack", ack, 1);
      chk("in2_stall", io_stall_cycles, 10);

      // Reset during WAIT_OUT
      operation_in = B_OUT; a_in = 8'h33; out_ready = 1'b0;
      @(negedge clk);
      operation_in = '0;
      chk("rwo_valid", out_valid, 1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("rwo_out_valid", out_valid, 0);
      chk("rwo_out_data", out_data, 0);
      chk("rwo_in_ready", in_ready, 0);
      chk("rwo_ack", ack, 1);
      chk("rwo_stall", io_stall_cycles, 0);

      // Reset during WAIT_IN; handshake and INC offered in the reset cycle are dropped
      operation_in = B_IN; dp_in = 16'h0300; in_valid = 1'b0;
      @(negedge clk);
      operation_in = '0;
      chk("rwi_ready", in_ready, 1);
      reset = 1'b1; in_valid = 1'b1; in_data = 8'hEE;
      operation_in = B_INC; dp_in = 16'h0777; a_in = 8'h77;
      @(negedge clk);
      reset = 1'b0; in_valid = 1'b0; operation_in = '0;
      chk("rwi_in_ready", in_ready, 0);
      chk("rwi_no_we", mem_we, 0);
      chk("rwi_waddr", mem_waddr, 0);
      chk("rwi_ack", ack, 1);
      chk("rwi_stall", io_stall_cycles, 0);
      @(negedge clk);
      chk("rwi_no_we2", mem_we, 0);

      // INC|OUT together: INC wins, no output transfer
      operation_in = B_INC | B_OUT; dp_in = 16'h0042; a_in = 8'h5A;
      push(16'h0042, 8'h5A);
      @(negedge clk);
      operation_in = '0;
      chk("prio_we", mem_we, 1);
      chk("prio_waddr", mem_waddr, 32'h0042);
      chk("prio_wdata", mem_wdata, 32'h5A);
      chk("prio_out_valid", out_valid, 0);
      chk("prio_ack", ack, 1);
      @(negedge clk);
      chk("prio_out_valid2", out_valid, 0);
      chk("prio_we_drop", mem_we, 0);

      @(negedge clk);
      chk("sb_drained", exp_q.size(), 0);
      done = 1'b1;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/stage_writeback.md
Name: stage_writeback

Overview:
- Final pipeline stage of the bfcpu2 datapath; the consumer of the modify stage's `a`/`operation` outputs.
- Commits results: INC/DEC results are written back to data memory at the current data pointer.
- OUT transfers the cell value to the output port over a valid/ready handshake.
- IN fetches a byte from the input port and writes it to data memory.
- Drives `ack` upstream; `ack` is the stall signal for the whole pipeline.

Parameters:
- D_WIDTH, 8, data cell / I/O byte width.
- A_WIDTH, 16, data memory address (data pointer) width.

Ports:
- clk  input  1  clock
- reset  input  1  reset; synchronous, active-high
- a_in  input  D_WIDTH  cell value from the modify stage
- dp_in  input  A_WIDTH  data pointer associated with `operation_in`
- operation_in  input  OPCODE_MSB+1  one-hot opcode vector from the modify stage; bit positions OP_INC, OP_DEC, OP_IN, OP_OUT per the shared constants header; all-zero = bubble
- ack  output  1  stage accepts `operation_in`/`a_in`/`dp_in` this cycle
- mem_we  output  1  data memory write strobe, one-cycle pulse
- mem_waddr  output  A_WIDTH  write address
- mem_wdata  output  D_WIDTH  write data
- out_valid  output  1  output byte valid
- out_data  output  D_WIDTH  output byte
- out_ready  input  1  output sink ready
- in_ready  output  1  stage requests an input byte
- in_data  input  D_WIDTH  input byte
- in_valid  input  1  input byte valid
- io_stall_cycles  output  16  saturating count of cycles spent in WAIT_IN or WAIT_OUT

Behaviour:
- Reset (synchronous, active-high): state=IDLE; mem_we=0; mem_waddr=0; mem_wdata=0; out_valid=0; out_data=0; in_ready=0; io_stall_cycles=0. Reset mid-handshake abandons the transfer, with no memory write.
- ack is combinational: ack = (state==IDLE). It is high during reset cycles, but inputs sampled in a reset cycle are discarded.
- mem_we defaults to 0 every cycle unless set below; it is never high for more than one consecutive cycle per operation.
- Opcode priority when multiple bits are set: INC, DEC, IN, OUT. Only the highest-priority set bit is acted on.
- IDLE, all bits zero: no action; stay in IDLE.
- IDLE, OP_INC or OP_DEC: next cycle mem_we=1, mem_waddr=dp_in, mem_wdata=a_in (already modified upstream). Stay IDLE. Latency 1 cycle; back-to-back accepts give a write every cycle.
- IDLE, OP_OUT: register out_data=a_in and out_valid=1; go to WAIT_OUT. No memory write.
- WAIT_OUT: hold out_data and out_valid. When out_valid&&out_ready, next cycle out_valid=0 and state=IDLE.
- IDLE, OP_IN: register the latched address dp_in, set in_ready=1, go to WAIT_IN. a_in is ignored.
- WAIT_IN: when in_valid&&in_ready, next cycle mem_we=1, mem_waddr=latched address, mem_wdata=in_data, in_ready=0, state=IDLE.
- If in_valid is already high on the first WAIT_IN cycle, the transfer completes that cycle (minimum IN latency 2 cycles accept-to-write).
- Minimum OUT occupancy: 1 WAIT_OUT cycle when out_ready is constantly high. The next accept occurs the cycle after the handshake.
- io_stall_cycles: increments by 1 each cycle with state != IDLE; saturates at 0xFFFF; cleared only by reset.
- Width rules: no arithmetic on data; the counter saturates and does not wrap; addresses pass through unmodified.

Test Plan:
- Reset, then INC with dp_in=0x0005, a_in=0x2A, ack=1 → next cycle mem_we=1, mem_waddr=0x0005, mem_wdata=0x2A; following cycle mem_we=0.
- Three back-to-back DEC ops (addr 1,2,3; data 0x10,0x11,0x12) → three consecutive mem_we pulses with matching addr/data; ack stays high throughout.
- OUT a_in=0x41 with out_ready low for 4 cycles then high → out_valid=1 and out_data=0x41 stable for 5 cycles; ack=0 for those cycles; out_valid drops after the handshake; io_stall_cycles=5.
- IN at dp_in=0x0100 with in_valid high at entry and in_data=0x7F → single WAIT_IN cycle; next cycle mem_we=1, mem_waddr=0x0100, mem_wdata=0x7F; ack returns high.
- IN with in_valid delayed 3 cycles while dp_in changes to 0x0200 → write still goes to 0x0100 with the in_data present at the handshake.
- Reset asserted during WAIT_OUT and during WAIT_IN → out_valid=0, in_ready=0, no mem_we, state IDLE, io_stall_cycles=0; operation_in with OP_INC|OP_OUT both set → memory write only, out_valid stays 0.
